usb_bus_master: RTL and testbench
=================================

# usb_bus_master

Bus-initiator for the SAM3U-to-FPGA 8-bit external-memory parallel bus (D, Addr, RDn, WRn, CEn, ALEn). It generates the host side of the register protocol: an address phase followed by an N-byte read or write burst, with programmable setup/strobe/hold timing. It is used as the host model in register-interface benches and as a bridge when a second FPGA or soft-core drives a CW register bank. Commands arrive on a valid/ready port. Write bytes stream in, and read bytes stream out.

## Interface
- SETUP_CYC, 2: cycles data/address are stable before a strobe falls (≥1)
- STROBE_CYC, 3: cycles RDn/WRn/ALEn are held low (≥1)
- HOLD_CYC, 1: cycles after a strobe rises before the next phase (≥1)
- TIMEOUT_CYC, 1024: write-data starvation limit (only with the timeout feature)
- clk  in  1  system clock; every bus output is registered on it
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  8  register address driven during the address phase
- cmd_len  in  16  burst length in bytes
- wdata_valid / wdata_ready  in/out  1  write byte handshake
- wdata  in  8  write byte
- rdata_valid  out  1  one-cycle pulse per read byte; there is no backpressure
- rdata  out  8  read byte
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse when a burst is aborted
- bus_addr  out  8  address lines
- bus_dout / bus_doe  out  8/1  data output value and its output enable
- bus_din  in  8  data bus input
- bus_alen, bus_cen, bus_rdn, bus_wrn  out  1  active-low strobes

## Operation
- State machine states: IDLE, ALE, GAP, WDATA, SETUP, STROBE, HOLD, DONE.
- IDLE
  - cmd_ready=1; the FSM leaves IDLE on cmd_valid.
  - cmd_write, cmd_addr and cmd_len are latched on acceptance.
  - cmd_len==0 goes directly to DONE with no bus activity.
- ALE: lasts STROBE_CYC cycles, with alen=0, cen=0 and bus_addr=latched address.
- GAP: lasts 1 cycle, with alen=1 and cen=0.
- Next state after GAP or HOLD (when bytes remain): writes go to WDATA, reads go to SETUP.
- WDATA
  - wdata_ready=1; the FSM stays here until wdata_valid.
  - The accepted byte is loaded into bus_dout and bus_doe=1.
  - Exit to SETUP.
- SETUP: lasts SETUP_CYC cycles with the strobe high. bus_doe=1 on writes and 0 on reads.
- STROBE
  - Lasts STROBE_CYC cycles with wrn=0 (write) or rdn=0 (read).
  - For reads, bus_din is sampled on the last STROBE cycle; rdata_valid pulses on the next cycle.
- HOLD
  - Lasts HOLD_CYC cycles; write data stays driven.
  - The 16-bit remaining count decrements at the end of HOLD.
  - Then: back to WDATA/SETUP, or to DONE when the count is 0.
- DONE: lasts 1 cycle with cen=1, bus_doe=0 and done=1, then returns to IDLE.
- bus_addr holds its value for the whole burst and does not increment; the responder's byte counter advances the location.
- bus_doe is never 1 while rdn=0.
- Reset (asynchronous, including mid-burst) forces these values immediately:
  - all strobes =1;
  - bus_doe=0;
  - bus_dout=0, bus_addr=0;
  - cmd_ready=0, then 1 on the first clock after release;
  - all pulses =0;
  - state IDLE.

## Timing
- Command accepted at cycle 0; all cycle numbers below are relative to it.
- Write burst of N bytes, wdata always valid: done asserts at cycle 1 + STROBE_CYC + 1 + N·(1+SETUP_CYC+STROBE_CYC+HOLD_CYC).
- Read burst: same formula without the WDATA term.
- Each phase counter is loaded with its parameter minus 1 on phase entry. Counter width is clog2 of the largest parameter.
- The next command is accepted no earlier than the cycle after DONE.

## Configuration
- USBBUS_WDATA_TIMEOUT_EN defined:
  - A counter runs while the FSM is in WDATA with wdata_valid=0.
  - When it reaches TIMEOUT_CYC, err and done pulse together (same cycle), cen=1, bus_doe=0, and the state returns to IDLE.
  - Bytes already written on the bus are not undone.
- Macro undefined: WDATA waits indefinitely, and err is tied to 0.

## Structure
- Shared package usb_bus_pkg holds:
  - the FSM state encoding constants;
  - the default SETUP/STROBE/HOLD/TIMEOUT values;
  - the bus width constants (8-bit data, 8-bit address).
- Sub-module usb_bus_phase_cnt: a loadable down-counter with a zero flag. It is shared by the ALE, SETUP, STROBE and HOLD phases and reused for the timeout.

## Test plan
- Write, addr=0x05, len=2, wdata 0xA5 then 0x3C, defaults:
  - alen low cycles 1–3;
  - wrn low cycles 8–10 (bus_dout 0xA5) and 15–17 (bus_dout 0x3C);
  - done at cycle 19.
- Read, addr=0x02, len=3, responder returns 0x11, 0x22, 0x33:
  - rdata_valid pulses carry 0x11, 0x22, 0x33 in order;
  - done at cycle 23;
  - bus_doe stays 0 throughout.
- cmd_len=0: done at cycle 1; bus strobes and cen never toggle.
- Write len=1 with wdata_valid delayed 10 cycles: wdata_ready held high for the wait, wrn stays 1 during it; done at cycle 22.
- Reset_n pulsed low while STROBE is mid-write: wrn=1, cen=1, bus_doe=0 in the same cycle; after release, cmd_ready=1 and a fresh read completes normally.
- With USBBUS_WDATA_TIMEOUT_EN and TIMEOUT_CYC=16, write len=2 with only 1 byte supplied:
  - one wrn strobe occurs;
  - err and done pulse 16 cycles after WDATA entry;
  - cen returns to 1.

Source files
------------

// File: rtl/usb_bus_pkg.sv
// rtl/usb_bus_pkg.sv - shared constants and types for the usb_bus_master slice
//
// Holds the FSM state encoding, the default bus timing values and the
// bus/command widths used by usb_bus_master and usb_bus_phase_cnt.
package usb_bus_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 16;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_STROBE_CYC  = 3;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALE    = 3'd1,
    ST_GAP    = 3'd2,
    ST_WDATA  = 3'd3,
    ST_SETUP  = 3'd4,
    ST_STROBE = 3'd5,
    ST_HOLD   = 3'd6,
    ST_DONE   = 3'd7
  } bus_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase counters hold value-1, so clog2(max) bits are enough; never 0 bits.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/usb_bus_phase_cnt.sv
// rtl/usb_bus_phase_cnt.sv - loadable down-counter with zero flag for bus phases
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load          load load_val this cycle (takes priority over en)
//   load_val      value loaded on entry to a phase (phase length - 1)
//   en            decrement enable; the counter stops at zero
//   zero          high while the count is zero (last cycle of the phase)
module usb_bus_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/usb_bus_master.sv
// rtl/usb_bus_master.sv - host-side initiator for the 8-bit SAM3U/FPGA register bus
//
// Issues an address phase (ALEn) followed by an N-byte read or write burst
// with programmable setup/strobe/hold timing. Optional feature macro:
// USBBUS_WDATA_TIMEOUT_EN aborts a write burst when write data starves.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_len                  command handshake and fields
//   wdata_valid/wdata_ready, wdata     write byte stream
//   rdata_valid, rdata                 read byte stream (no backpressure)
//   done, err                          completion / abort pulses
//   bus_addr, bus_dout, bus_doe,
//   bus_din                            bus address and data lines
//   bus_alen, bus_cen, bus_rdn, bus_wrn  active-low bus strobes
module usb_bus_master
  import usb_bus_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_doe,
  input  logic [DATA_W-1:0] bus_din,
  output logic              bus_alen,
  output logic              bus_cen,
  output logic              bus_rdn,
  output logic              bus_wrn
);

  localparam int CNT_MAX = max2(max2(SETUP_CYC, STROBE_CYC), max2(HOLD_CYC, TIMEOUT_CYC));
  localparam int CNT_W   = cnt_width(CNT_MAX);

  bus_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              alen_q, alen_d;
  logic              cen_q, cen_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wdata_ready_q, wdata_ready_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_en;
  logic              cnt_zero;

`ifdef USBBUS_WDATA_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    rem_d         = rem_q;
    addr_d        = addr_q;
    dout_d        = dout_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
`ifdef USBBUS_WDATA_TIMEOUT_EN
    err_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? ST_DONE : ST_ALE;
        end
      end
      ST_ALE: begin
        if (cnt_zero) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = wr_q ? ST_WDATA : ST_SETUP;
      end
      ST_WDATA: begin
        if (wdata_valid) begin
          dout_d  = wdata;
          state_d = ST_SETUP;
        end
`ifdef USBBUS_WDATA_TIMEOUT_EN
        else if (cnt_zero) begin
          // Starved: abort; bytes already strobed stay written.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_SETUP: begin
        if (cnt_zero) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          if (!wr_q) begin
            rdata_d       = bus_din;
            rdata_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = wr_q ? ST_WDATA : ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so each pin changes on
  // the same edge as the phase it belongs to.
  always_comb begin
    alen_d        = (state_d != ST_ALE);
    cen_d         = (state_d == ST_IDLE) || (state_d == ST_DONE);
    rdn_d         = !((state_d == ST_STROBE) && !wr_d);
    wrn_d         = !((state_d == ST_STROBE) && wr_d);
    doe_d         = wr_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                             (state_d == ST_HOLD));
    cmd_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_WDATA);
    done_d        = (state_d == ST_DONE);
  end

  // One shared counter: reloaded on every phase change with that phase's length - 1.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_en       = !((state_q == ST_WDATA) && wdata_valid);
    cnt_load_val = '0;
    case (state_d)
      ST_ALE:    cnt_load_val = CNT_W'(STROBE_CYC - 1);
      ST_SETUP:  cnt_load_val = CNT_W'(SETUP_CYC - 1);
      ST_STROBE: cnt_load_val = CNT_W'(STROBE_CYC - 1);
      ST_HOLD:   cnt_load_val = CNT_W'(HOLD_CYC - 1);
`ifdef USBBUS_WDATA_TIMEOUT_EN
      ST_WDATA:  cnt_load_val = CNT_W'(TIMEOUT_CYC - 1);
`endif
      default:   cnt_load_val = '0;
    endcase
  end

  usb_bus_phase_cnt #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wr_q          <= 1'b0;
      rem_q         <= '0;
      addr_q        <= '0;
      dout_q        <= '0;
      doe_q         <= 1'b0;
      alen_q        <= 1'b1;
      cen_q         <= 1'b1;
      rdn_q         <= 1'b1;
      wrn_q         <= 1'b1;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      rem_q         <= rem_d;
      addr_q        <= addr_d;
      dout_q        <= dout_d;
      doe_q         <= doe_d;
      alen_q        <= alen_d;
      cen_q         <= cen_d;
      rdn_q         <= rdn_d;
      wrn_q         <= wrn_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
    end
  end

`ifdef USBBUS_WDATA_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign bus_addr    = addr_q;
  assign bus_dout    = dout_q;
  assign bus_doe     = doe_q;
  assign bus_alen    = alen_q;
  assign bus_cen     = cen_q;
  assign bus_rdn     = rdn_q;
  assign bus_wrn     = wrn_q;

endmodule

// File: tb/tb_usb_bus_master.sv
// tb/tb_usb_bus_master.sv - self-checking bench for usb_bus_master
module tb_usb_bus_master;

  localparam int SU = 2;
  localparam int ST = 3;
  localparam int HD = 1;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr;
  logic [15:0] cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid;
  logic [7:0] rdata;
  logic       done, err;
  logic [7:0] bus_addr, bus_dout, bus_din;
  logic       bus_doe, bus_alen, bus_cen, bus_rdn, bus_wrn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usb_bus_master #(
    .SETUP_CYC   (SU),
    .STROBE_CYC  (ST),
    .HOLD_CYC    (HD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .done        (done),
    .err         (err),
    .bus_addr    (bus_addr),
    .bus_dout    (bus_dout),
    .bus_doe     (bus_doe),
    .bus_din     (bus_din),
    .bus_alen    (bus_alen),
    .bus_cen     (bus_cen),
    .bus_rdn     (bus_rdn),
    .bus_wrn     (bus_wrn)
  );

  // Stimulus sources
  logic [7:0] wq[$];
  int         wdly[$];
  logic [7:0] resp[$];

  // Observations of one command (cycle 0 = acceptance cycle)
  int o_done, o_err, o_done_cen, o_alen_first, o_alen_n, o_cen_low_n;
  int o_addr_bad, o_doe_rd, o_doe_n, o_wrong_strb, o_rdy_n, o_wrn_in_rdy;
  int s_start[$];
  int s_len[$];
  logic [7:0] s_dout[$];
  int rv_cyc[$];
  logic [7:0] rv_dat[$];

  // Reference model results
  int e_done;
  int e_strb[$];

  // Timing model: ALE for ST cycles from cycle 1, one GAP cycle, then per byte
  // an optional WDATA wait (1 + delay), SETUP, STROBE and HOLD; DONE follows.
  task automatic model(input bit wr, input int n);
    int t;
    e_strb.delete();
    if (n == 0) begin
      e_done = 1;
      return;
    end
    t = 1 + ST + 1;
    for (int i = 0; i < n; i++) begin
      if (wr) t += 1 + wdly[i];
      e_strb.push_back(t + SU);
      t += SU + ST + HD;
    end
    e_done = t;
  endtask

  task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [15:0] len,
                         input int budget);
    int bi, ri, wt;
    bit low, prev_low;
    o_done = -1; o_err = -1; o_done_cen = -1; o_alen_first = -1; o_alen_n = 0;
    o_cen_low_n = 0; o_addr_bad = 0; o_doe_rd = 0; o_doe_n = 0; o_wrong_strb = 0;
    o_rdy_n = 0; o_wrn_in_rdy = 0;
    s_start.delete(); s_len.delete(); s_dout.delete(); rv_cyc.delete(); rv_dat.delete();
    for (int k = 0; k < 50 && cmd_ready !== 1'b1; k++) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    bi = 0; ri = 0; wt = 0; prev_low = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (!bus_alen) begin
        if (o_alen_n == 0) o_alen_first = c;
        o_alen_n++;
      end
      if (!bus_cen) begin
        o_cen_low_n++;
        if (bus_addr !== addr) o_addr_bad++;
      end
      if (bus_doe && !bus_rdn) o_doe_rd++;
      if (!wr && bus_doe) o_doe_n++;
      if ((wr && !bus_rdn) || (!wr && !bus_wrn)) o_wrong_strb++;
      low = wr ? !bus_wrn : !bus_rdn;
      if (low && !prev_low) begin
        s_start.push_back(c); s_len.push_back(1); s_dout.push_back(bus_dout);
      end else if (low) begin
        s_len[s_len.size()-1] = s_len[s_len.size()-1] + 1;
      end
      if (rdata_valid) begin
        rv_cyc.push_back(c); rv_dat.push_back(rdata);
      end
      if (err && o_err < 0) o_err = c;
      if (wdata_ready) begin
        o_rdy_n++;
        if (!bus_wrn) o_wrn_in_rdy++;
      end
      // Write source: valid raised only while ready is high, so it was taken.
      if (wdata_valid) begin
        wdata_valid = 1'b0; bi++; wt = 0;
      end else if (wdata_ready && bi < wq.size()) begin
        if (wt >= wdly[bi]) begin
          wdata = wq[bi]; wdata_valid = 1'b1;
        end else begin
          wt++;
        end
      end
      // Read responder: one byte per rdn strobe.
      if (!wr && prev_low && !low) ri++;
      if (!wr && low) bus_din = (ri < resp.size()) ? resp[ri] : 8'h00;
      prev_low = low;
      if (done) begin
        o_done = c; o_done_cen = bus_cen;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_alen, bus_cen, bus_rdn, bus_wrn} !== 4'b1111) begin
      errors++; $display("FAIL reset_strobes: got %b expected 1111", {bus_alen, bus_cen, bus_rdn, bus_wrn});
    end
    checks++;
    if ({bus_doe, bus_dout, bus_addr} !== 17'h0) begin
      errors++; $display("FAIL reset_bus: got doe=%b dout=%h addr=%h expected 0", bus_doe, bus_dout, bus_addr);
    end
    checks++;
    if ({cmd_ready, wdata_ready, done, err, rdata_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {cmd_ready, wdata_ready, done, err, rdata_valid});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_release: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    wq = '{8'hA5, 8'h3C}; wdly = '{0, 0};
    run_cmd(1'b1, 8'h05, 16'd2, 60);
    checks++;
    if (o_alen_first !== 1 || o_alen_n !== 3) begin
      errors++; $display("FAIL wr_alen: got first=%0d n=%0d expected first=1 n=3", o_alen_first, o_alen_n);
    end
    checks++;
    if (s_start.size() !== 2) begin
      errors++; $display("FAIL wr_strobe_count: got %0d expected 2", s_start.size());
    end else begin
      checks++;
      if (s_start[0] !== 8 || s_len[0] !== 3 || s_dout[0] !== 8'hA5) begin
        errors++; $display("FAIL wr_strobe0: got start=%0d len=%0d dout=%h expected 8 3 a5", s_start[0], s_len[0], s_dout[0]);
      end
      checks++;
      if (s_start[1] !== 15 || s_len[1] !== 3 || s_dout[1] !== 8'h3C) begin
        errors++; $display("FAIL wr_strobe1: got start=%0d len=%0d dout=%h expected 15 3 3c", s_start[1], s_len[1], s_dout[1]);
      end
    end
    checks++;
    if (o_done !== 19) begin
      errors++; $display("FAIL wr_done: got %0d expected 19", o_done);
    end
    checks++;
    if (o_addr_bad !== 0 || o_wrong_strb !== 0) begin
      errors++; $display("FAIL wr_addr_strb: got addr_bad=%0d wrong=%0d expected 0 0", o_addr_bad, o_wrong_strb);
    end
  endtask

  task automatic test_read_basic();
    resp = '{8'h11, 8'h22, 8'h33};
    run_cmd(1'b0, 8'h02, 16'd3, 60);
    checks++;
    if (rv_dat.size() !== 3) begin
      errors++; $display("FAIL rd_count: got %0d expected 3", rv_dat.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rv_dat[i] !== resp[i] || rv_cyc[i] !== 10 + 6 * i) begin
          errors++; $display("FAIL rd_byte%0d: got %h@%0d expected %h@%0d", i, rv_dat[i], rv_cyc[i], resp[i], 10 + 6 * i);
        end
      end
    end
    checks++;
    if (o_done !== 23) begin
      errors++; $display("FAIL rd_done: got %0d expected 23", o_done);
    end
    checks++;
    if (o_doe_n !== 0 || o_doe_rd !== 0) begin
      errors++; $display("FAIL rd_doe: got doe cycles=%0d expected 0", o_doe_n);
    end
  endtask

  task automatic test_len_zero();
    run_cmd(1'b1, 8'h44, 16'd0, 20);
    checks++;
    if (o_done !== 1) begin
      errors++; $display("FAIL len0_done: got %0d expected 1", o_done);
    end
    checks++;
    if (o_cen_low_n !== 0 || o_alen_n !== 0 || s_start.size() !== 0) begin
      errors++; $display("FAIL len0_bus: got cen_low=%0d alen=%0d strobes=%0d expected 0", o_cen_low_n, o_alen_n, s_start.size());
    end
  endtask

  task automatic test_wdata_delay();
    wq = '{8'h5A}; wdly = '{10};
    run_cmd(1'b1, 8'h09, 16'd1, 60);
    checks++;
    if (o_done !== 22) begin
      errors++; $display("FAIL delay_done: got %0d expected 22", o_done);
    end
    checks++;
    if (o_rdy_n !== 11 || o_wrn_in_rdy !== 0) begin
      errors++; $display("FAIL delay_ready: got ready=%0d wrn_low=%0d expected 11 0", o_rdy_n, o_wrn_in_rdy);
    end
    checks++;
    if (s_start.size() !== 1 || s_start[0] !== 18 || s_dout[0] !== 8'h5A) begin
      errors++; $display("FAIL delay_strobe: got n=%0d expected one strobe at 18 with 5a", s_start.size());
    end
  endtask

  task automatic test_back_to_back();
    resp = '{8'h96};
    run_cmd(1'b0, 8'h31, 16'd1, 40);
    checks++;
    if (o_done !== 11 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got done=%0d ready=%b expected 11 0", o_done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready);
    end
    wq = '{8'h69}; wdly = '{0};
    run_cmd(1'b1, 8'h32, 16'd1, 40);
    checks++;
    if (o_done !== 12) begin
      errors++; $display("FAIL b2b_second: got %0d expected 12", o_done);
    end
  endtask

  task automatic test_random();
    bit wr;
    int n;
    logic [7:0] a;
    for (int it = 0; it < 8; it++) begin
      wr = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 4));
      a  = 8'($urandom);
      wq.delete(); wdly.delete(); resp.delete();
      for (int i = 0; i < n; i++) begin
        wq.push_back(8'($urandom));
        wdly.push_back(int'($urandom_range(0, 3)));
        resp.push_back(8'($urandom));
      end
      model(wr, n);
      run_cmd(wr, a, 16'(n), 100);
      checks++;
      if (o_done !== e_done) begin
        errors++; $display("FAIL rnd%0d_done: got %0d expected %0d", it, o_done, e_done);
      end
      checks++;
      if (o_addr_bad !== 0 || o_wrong_strb !== 0 || o_doe_rd !== 0) begin
        errors++; $display("FAIL rnd%0d_bus: got addr_bad=%0d wrong=%0d doe_rd=%0d expected 0", it, o_addr_bad, o_wrong_strb, o_doe_rd);
      end
      checks++;
      if (s_start.size() !== n) begin
        errors++; $display("FAIL rnd%0d_strobes: got %0d expected %0d", it, s_start.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (s_start[i] !== e_strb[i] || s_len[i] !== ST || (wr && s_dout[i] !== wq[i])) begin
            errors++; $display("FAIL rnd%0d_strobe%0d: got %0d/%0d/%h expected %0d/%0d/%h", it, i, s_start[i], s_len[i], s_dout[i], e_strb[i], ST, wq[i]);
          end
        end
      end
      if (!wr) begin
        checks++;
        if (rv_dat.size() !== n) begin
          errors++; $display("FAIL rnd%0d_rdcount: got %0d expected %0d", it, rv_dat.size(), n);
        end else begin
          for (int i = 0; i < n; i++) begin
            checks++;
            if (rv_dat[i] !== resp[i] || rv_cyc[i] !== e_strb[i] + ST) begin
              errors++; $display("FAIL rnd%0d_rd%0d: got %h@%0d expected %h@%0d", it, i, rv_dat[i], rv_cyc[i], resp[i], e_strb[i] + ST);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int k = 0; k < 50 && cmd_ready !== 1'b1; k++) @(negedge clk);
    wdata = 8'h77; wdata_valid = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h12; cmd_len = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (!bus_wrn) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midrst_strobe: got no wrn strobe expected one within 40 cycles");
    end
    reset_n = 1'b0;
    wdata_valid = 1'b0;
    #1;
    checks++;
    if ({bus_wrn, bus_cen, bus_doe, cmd_ready} !== 4'b1100) begin
      errors++; $display("FAIL midrst_outputs: got wrn,cen,doe,ready=%b expected 1100", {bus_wrn, bus_cen, bus_doe, cmd_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
    resp = '{8'hC3};
    run_cmd(1'b0, 8'h10, 16'd1, 40);
    checks++;
    if (o_done !== 11 || rv_dat.size() !== 1 || rv_dat[0] !== 8'hC3) begin
      errors++; $display("FAIL midrst_read: got done=%0d n=%0d expected done=11 one byte c3", o_done, rv_dat.size());
    end
  endtask

`ifdef USBBUS_WDATA_TIMEOUT_EN
  task automatic test_timeout();
    wq = '{8'h81}; wdly = '{0};
    run_cmd(1'b1, 8'h20, 16'd2, 80);
    checks++;
    if (s_start.size() !== 1) begin
      errors++; $display("FAIL to_strobes: got %0d expected 1", s_start.size());
    end
    // Second WDATA entered at cycle 12; abort lands TO cycles later.
    checks++;
    if (o_done !== 12 + TO || o_err !== 12 + TO) begin
      errors++; $display("FAIL to_err_done: got done=%0d err=%0d expected %0d", o_done, o_err, 12 + TO);
    end
    checks++;
    if (o_done_cen !== 1) begin
      errors++; $display("FAIL to_cen: got %0d expected 1", o_done_cen);
    end
  endtask
`endif

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; bus_din = '0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_len_zero();
    test_wdata_delay();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef USBBUS_WDATA_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
